// File: rtl/mmio_switch_led_port_if.sv
// Bus interface between the memory stage and the switch/LED I/O port.
// The memory stage (master) forwards the window offset, store data and
// strobes; the port (slave) returns read data combinationally.
interface mmio_switch_led_port_if;
   logic [7:0]  addr;
   logic [63:0] write_data;
   logic        MemWrite;
   logic        MemRead;
   logic [63:0] read_data;

   modport master (
      output addr,
      output write_data,
      output MemWrite,
      output MemRead,
      input  read_data
   );

   modport slave (
      input  addr,
      input  write_data,
      input  MemWrite,
      input  MemRead,
      output read_data
   );
endinterface

// File: rtl/mmio_switch_led_port.sv
// Memory-mapped switch/LED port.
// - Two-flop synchronizer and tick-sampled debounce on 18 switches.
// - Sticky write-1-to-clear change flags; a set in the same cycle as a clear wins.
// - 27 registered LED outputs, optionally XORed with a hardware blink mask.
// Register select is addr[5:3]:
//   0 SW_STATE, 1 SW_CHANGED, 2 LED_OUT, 3 LED_BLINK, 4 BLINK_DIV.
// Define MMIO_BLINK_EN to build the blink counter, phase, LED_BLINK and
// BLINK_DIV; without it those registers read 0 and leds follow LED_OUT.
module mmio_switch_led_port #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic                          clock,
   input  logic                          reset,
   mmio_switch_led_port_if.slave         bus,
   input  logic [17:0]                   switches,
   output logic [26:0]                   leds
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Register select decode.
   logic [2:0] sel;
   logic       wr_changed;
   logic       wr_led_out;
   assign sel        = bus.addr[5:3];
   assign wr_changed = bus.MemWrite && (sel == 3'd1);
   assign wr_led_out = bus.MemWrite && (sel == 3'd2);

   // Address and data bits that no register uses.
   logic unused_bits;
   assign unused_bits = ^{bus.addr[7:6], bus.addr[2:0], bus.write_data[63:27]};

   // Core state.
   logic [17:0]      sw_meta_q, sw_sync_q;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [17:0]      sample_q, sample_d;
   logic [17:0]      sw_state_q, sw_state_d;
   logic [17:0]      sw_changed_q, sw_changed_d;
   logic [26:0]      led_out_q, led_out_d;
   logic [26:0]      leds_q, leds_d;
   logic             tick;
   logic [17:0]      agree;
   logic [17:0]      clr_mask;

   // Blink-dependent values seen by the shared logic.
   logic [26:0]      blink_mask;
   logic [26:0]      led_blink_rd;
   logic [23:0]      blink_div_rd;

   // Debounce, change flags, LED register and output next-state.
   always_comb begin
      tick         = (tick_cnt_q == TICK_LAST);
      tick_cnt_d   = tick ? '0 : tick_cnt_q + CNT_W'(1);
      sample_d     = tick ? sw_sync_q : sample_q;
      // A bit is accepted only when two consecutive samples agree.
      agree        = ~(sw_sync_q ^ sample_q);
      sw_state_d   = sw_state_q;
      if (tick) begin
         sw_state_d = (sw_state_q & ~agree) | (sw_sync_q & agree);
      end
      clr_mask     = wr_changed ? bus.write_data[17:0] : 18'd0;
      // New edges are ORed in after the clear so a simultaneous set wins.
      sw_changed_d = (sw_changed_q & ~clr_mask) | (sw_state_d ^ sw_state_q);
      led_out_d    = wr_led_out ? bus.write_data[26:0] : led_out_q;
      leds_d       = led_out_q ^ blink_mask;
   end

   // Core state registers, cleared asynchronously.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sw_meta_q    <= '0;
         sw_sync_q    <= '0;
         tick_cnt_q   <= '0;
         sample_q     <= '0;
         sw_state_q   <= '0;
         sw_changed_q <= '0;
         led_out_q    <= '0;
         leds_q       <= '0;
      end else begin
         sw_meta_q    <= switches;
         sw_sync_q    <= sw_meta_q;
         tick_cnt_q   <= tick_cnt_d;
         sample_q     <= sample_d;
         sw_state_q   <= sw_state_d;
         sw_changed_q <= sw_changed_d;
         led_out_q    <= led_out_d;
         leds_q       <= leds_d;
      end
   end

   assign leds = leds_q;

`ifdef MMIO_BLINK_EN
   logic        wr_led_blink;
   logic        wr_blink_div;
   logic [26:0] led_blink_q, led_blink_d;
   logic [23:0] blink_div_q, blink_div_d;
   logic [23:0] blink_cnt_q, blink_cnt_d;
   logic        phase_q, phase_d;

   assign wr_led_blink = bus.MemWrite && (sel == 3'd3);
   assign wr_blink_div = bus.MemWrite && (sel == 3'd4);

   // Blink divider: phase toggles every BLINK_DIV cycles, frozen at 0 when
   // the divider is 0; rewriting the divider restarts the count only.
   always_comb begin
      led_blink_d = wr_led_blink ? bus.write_data[26:0] : led_blink_q;
      blink_div_d = wr_blink_div ? bus.write_data[23:0] : blink_div_q;
      blink_cnt_d = blink_cnt_q + 24'd1;
      phase_d     = phase_q;
      if (wr_blink_div) begin
         blink_cnt_d = '0;
      end else if (blink_div_q == 24'd0) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (blink_cnt_q == blink_div_q - 24'd1) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end
   end

   // Blink state registers, cleared asynchronously.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         led_blink_q <= '0;
         blink_div_q <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else begin
         led_blink_q <= led_blink_d;
         blink_div_q <= blink_div_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end

   assign blink_mask   = led_blink_q & {27{phase_q}};
   assign led_blink_rd = led_blink_q;
   assign blink_div_rd = blink_div_q;
`else
   assign blink_mask   = '0;
   assign led_blink_rd = '0;
   assign blink_div_rd = '0;
`endif

   // Combinational read mux; shows pre-write contents during a store.
   always_comb begin
      bus.read_data = '0;
      if (bus.MemRead) begin
         case (sel)
            3'd0:    bus.read_data = {46'd0, sw_state_q};
            3'd1:    bus.read_data = {46'd0, sw_changed_q};
            3'd2:    bus.read_data = {37'd0, led_out_q};
            3'd3:    bus.read_data = {37'd0, led_blink_rd};
            3'd4:    bus.read_data = {40'd0, blink_div_rd};
            default: bus.read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_switch_led_port.sv
// Self-checking bench for mmio_switch_led_port (DEBOUNCE_CYCLES = 4).
// Expected values are queued when stimulus is applied and popped when the
// DUT output is sampled. Blink checks follow MMIO_BLINK_EN.
module tb_mmio_switch_led_port;
   localparam int DB = 4;

   logic        clock;
   logic        reset;
   logic [17:0] switches;
   logic [26:0] leds;
   int          ecnt;

   mmio_switch_led_port_if bus();

   mmio_switch_led_port #(.DEBOUNCE_CYCLES(DB)) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .switches (switches),
      .leds     (leds)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Edges since reset release, mirrors where the debounce tick falls.
   always @(posedge clock or negedge reset) begin
      if (!reset) ecnt <= 0;
      else        ecnt <= ecnt + 1;
   end

   int          n_chk = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];
   string       tag_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [63:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   task automatic sb_pop(input logic [63:0] got);
      if (exp_q.size() == 0) begin
         chk("sb_empty", 64'd1, 64'd0);
      end else begin
         chk(tag_q.pop_front(), got, exp_q.pop_front());
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [63:0] d);
      bus.addr = a; bus.write_data = d; bus.MemWrite = 1'b1;
      step(1);
      bus.MemWrite = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [63:0] exp, input string tag);
      bus.addr = a; bus.MemRead = 1'b1;
      sb_push(tag, exp);
      #1;
      sb_pop(bus.read_data);
      bus.MemRead = 1'b0;
   endtask

   task automatic led_chk(input logic [26:0] exp, input string tag);
      sb_push(tag, {37'd0, exp});
      sb_pop({37'd0, leds});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      bit  seen;
      reset = 1'b0;
      switches = '0;
      bus.addr = '0; bus.write_data = '0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
      #1;
      led_chk(27'd0, "rst_leds");
      for (int r = 0; r < 8; r++) rd(8'(r << 3), 64'd0, "rst_reg");
      step(2);
      reset = 1'b1;
      step(1);

      // LED path with blink divider at 0.
      wr(8'h20, 64'd0);
      wr(8'h10, 64'h5555555);
      led_chk(27'd0, "led_lat1");
      step(1);
      led_chk(27'h5555555, "led_lat2");
      rd(8'h10, 64'h5555555, "led_rd");

      // Decode, simultaneous read+write, read strobe gating.
      rd(8'h28, 64'd0, "sel5_rd");
      wr(8'h10, 64'h1);
      bus.addr = 8'h10; bus.write_data = 64'h2; bus.MemWrite = 1'b1; bus.MemRead = 1'b1;
      sb_push("rw_old", 64'h1);
      #1;
      sb_pop(bus.read_data);
      step(1);
      bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
      rd(8'h10, 64'h2, "rw_new");
      bus.addr = 8'h10;
      sb_push("rd_gate", 64'd0);
      #1;
      sb_pop(bus.read_data);
      wr(8'hD7, 64'hFFFF_FFFF_FFFF_FFFF);
      rd(8'h10, 64'h7FFFFFF, "led_trunc");
      wr(8'h10, 64'd0);
      wr(8'h2F, 64'hFFFF);
      rd(8'h28, 64'd0, "sel5_wr");
      step(2);

      // Blink.
      wr(8'h18, 64'hFFFF_FFFF_0000_0F0F);
      wr(8'h20, 64'hFFFF_FFFF_FF00_0003);
`ifdef MMIO_BLINK_EN
      rd(8'h18, 64'h0000F0F, "blink_rd");
      rd(8'h20, 64'h3, "div_rd");
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         step(1);
         if (leds == 27'h0000F0F) seen = 1'b1;
      end
      chk("blink_start", {63'd0, seen}, 64'd1);
      for (int k = 1; k < 12; k++) begin
         sb_push("blink_seq", ((k / 3) % 2 == 0) ? 64'hF0F : 64'h0);
         step(1);
         sb_pop({37'd0, leds});
      end
      wr(8'h20, 64'd0);
      wr(8'h18, 64'd0);
      step(2);
      led_chk(27'd0, "blink_off");
`else
      rd(8'h18, 64'd0, "blink_rd0");
      rd(8'h20, 64'd0, "div_rd0");
      for (int k = 0; k < 8; k++) begin
         sb_push("blink_none", 64'd0);
         step(1);
         sb_pop({37'd0, leds});
      end
`endif

      // Debounce latency and change flags.
      switches = 18'h2A5A5;
      lat = 0;
      bus.addr = 8'h00; bus.MemRead = 1'b1;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         @(posedge clock); #2;
         if (bus.read_data == 64'h2A5A5) lat = c;
      end
      bus.MemRead = 1'b0;
      chk("db_latency_ok", {63'd0, (lat != 0 && lat <= 10)}, 64'd1);
      rd(8'h00, 64'h2A5A5, "db_state");
      rd(8'h08, 64'h2A5A5, "db_changed");

      // Glitch shorter than a tick period.
      step(1);
      switches[0] = 1'b0;
      step(3);
      switches[0] = 1'b1;
      for (int c = 0; c < 16; c++) begin
         step(1);
         if (c % 5 == 4) rd(8'h00, 64'h2A5A5, "glitch_state");
      end
      rd(8'h08, 64'h2A5A5, "glitch_changed");

      // Clear racing a new debounced value on bit 0.
      wr(8'h08, 64'h3FFFF);
      rd(8'h08, 64'd0, "chg_clear");
      while (ecnt % DB != 1) step(1);
      switches[0] = 1'b0;
      step(6);
      wr(8'h08, 64'h1);
      rd(8'h00, 64'h2A5A4, "race_state");
      rd(8'h08, 64'h1, "race_changed");
      wr(8'h08, 64'h3FFFF);
      rd(8'h08, 64'd0, "race_clear");

      // Asynchronous reset mid-traffic.
      wr(8'h10, 64'h7FFFFFF);
      step(1);
      led_chk(27'h7FFFFFF, "pre_rst_leds");
      #3;
      reset = 1'b0;
      #1;
      led_chk(27'd0, "async_rst_leds");
      for (int r = 0; r < 5; r++) rd(8'(r << 3), 64'd0, "mid_rst_reg");
      step(2);
      reset = 1'b1;
      step(7);
      rd(8'h00, 64'd0, "post_rst_pre");
      step(1);
      rd(8'h00, 64'h2A5A4, "post_rst_tick");

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
